present_key_schedule: RTL and testbench

Sequential PRESENT key-schedule engine that generates all 32 64-bit round keys, one per handshake, from an 80- or 128-bit user key. It holds the evolving key register and applies one schedule update per accepted round key. It sits between the key-load interface and the round datapath, replacing per-round combinational key-update instances with a single parametrised, flow-controlled block.

---
 rtl/present_pkg.sv | 23 ++
 rtl/present_key_round.sv | 33 +++
 rtl/present_key_schedule.sv | 119 +++++++++++
 tb/tb_present_key_schedule.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants, state encoding and S-box for the PRESENT key schedule.
package present_pkg;

    localparam int ROUND_KEY_W    = 64;
    localparam int NUM_ROUND_KEYS = 32;
    localparam int ROUND_CNT_W    = 5;

    // Element x holds S(x); listed from entry 15 down to entry 0.
    localparam logic [15:0][3:0] SBOX = {
        4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
        4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present_key_round.sv
// One PRESENT key-schedule update: rotate left 61, S-box the top nibble(s), xor in the round counter.
module present_key_round
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80
) (
    input  logic [KEY_WIDTH-1:0]   key,
    input  logic [ROUND_CNT_W-1:0] round,
    output logic [KEY_WIDTH-1:0]   key_next
);

    logic [KEY_WIDTH-1:0] rotated;

    assign rotated = {key[KEY_WIDTH-62:0], key[KEY_WIDTH-1:KEY_WIDTH-61]};

    generate
        if (KEY_WIDTH == 128) begin : g_k128
            always_comb begin
                key_next          = rotated;
                key_next[127:124] = sbox4(rotated[127:124]);
                key_next[123:120] = sbox4(rotated[123:120]);
                key_next[66:62]   = rotated[66:62] ^ round;
            end
        end else begin : g_k80
            always_comb begin
                key_next        = rotated;
                key_next[79:76] = sbox4(rotated[79:76]);
                key_next[19:15] = rotated[19:15] ^ round;
            end
        end
    endgenerate

endmodule

// File: rtl/present_key_schedule.sv
// Flow-controlled PRESENT key schedule emitting 32 round keys per loaded key.
// Optional macro PRESENT_KS_LAST_KEY_EN adds a captured final key register for decryption preload.
module present_key_schedule
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80,
    parameter int NUM_RK    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   key_i,
    input  logic                   key_valid_i,
    output logic                   key_ready_o,
    output logic [ROUND_KEY_W-1:0] rk_o,
    output logic                   rk_valid_o,
    input  logic                   rk_ready_i,
    output logic [ROUND_CNT_W-1:0] round_o,
    output logic                   last_o,
`ifdef PRESENT_KS_LAST_KEY_EN
    output logic [KEY_WIDTH-1:0]   last_key_o,
    output logic                   last_key_valid_o,
`endif
    output state_t                 state_o
);

    generate
        if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_width
            $error("present_key_schedule: KEY_WIDTH must be 80 or 128");
        end
        if (NUM_RK != NUM_ROUND_KEYS) begin : g_bad_count
            $error("present_key_schedule: NUM_RK must be 32");
        end
    endgenerate

    state_t                 state, state_next;
    logic [KEY_WIDTH-1:0]   key_reg, key_upd;
    logic [ROUND_CNT_W-1:0] cnt;
    logic                   load, advance, finish;

    present_key_round #(.KEY_WIDTH(KEY_WIDTH)) u_round (
        .key      (key_reg),
        .round    (cnt),
        .key_next (key_upd)
    );

    // Both interfaces use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid-side data stays stable until then.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        key_ready_o = 1'b0;
        rk_valid_o  = 1'b0;
        last_o      = 1'b0;
        case (state)
            IDLE: begin
                key_ready_o = 1'b1;
                if (key_valid_i) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                rk_valid_o = 1'b1;
                last_o     = (cnt == '0);
                if (rk_ready_i) begin
                    if (cnt == '0) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            key_reg <= '0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                key_reg <= key_i;
                cnt     <= ROUND_CNT_W'(1);
            end else if (advance) begin
                // Counter 31 wraps to 0, which tags round key 32.
                key_reg <= key_upd;
                cnt     <= cnt + ROUND_CNT_W'(1);
            end
        end
    end

    assign rk_o    = key_reg[KEY_WIDTH-1 -: ROUND_KEY_W];
    assign round_o = cnt;
    assign state_o = state;

`ifdef PRESENT_KS_LAST_KEY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_key_o       <= '0;
            last_key_valid_o <= 1'b0;
        end else if (load) begin
            last_key_valid_o <= 1'b0;
        end else if (finish) begin
            last_key_o       <= key_reg;
            last_key_valid_o <= 1'b1;
        end
    end
`else
    logic unused_finish;
    assign unused_finish = finish;
`endif

endmodule

// File: tb/tb_present_key_schedule.sv
// Bench for present_key_schedule: an 80-bit and a 128-bit instance checked every cycle against a behavioural model.
module tb_present_key_schedule;
  import present_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index 0: 80-bit, 1: 128-bit) ----------------
  logic [127:0] key_in[2];
  logic         kv[2];
  logic         rr[2];
  logic         kr[2];
  logic         rv[2];
  logic         last_o[2];
  logic [63:0]  rk[2];
  logic [4:0]   rnd[2];
  state_t       st[2];
`ifdef PRESENT_KS_LAST_KEY_EN
  logic [79:0]  lk80;
  logic [127:0] lk128;
  logic         lkv[2];
`endif

  int wid[2] = '{80, 128};

  present_key_schedule #(.KEY_WIDTH(80), .NUM_RK(32)) dut80 (
    .clk(clk), .rst(rst),
    .key_i(key_in[0][79:0]), .key_valid_i(kv[0]), .key_ready_o(kr[0]),
    .rk_o(rk[0]), .rk_valid_o(rv[0]), .rk_ready_i(rr[0]),
    .round_o(rnd[0]), .last_o(last_o[0]),
`ifdef PRESENT_KS_LAST_KEY_EN
    .last_key_o(lk80), .last_key_valid_o(lkv[0]),
`endif
    .state_o(st[0])
  );

  present_key_schedule #(.KEY_WIDTH(128), .NUM_RK(32)) dut128 (
    .clk(clk), .rst(rst),
    .key_i(key_in[1]), .key_valid_i(kv[1]), .key_ready_o(kr[1]),
    .rk_o(rk[1]), .rk_valid_o(rv[1]), .rk_ready_i(rr[1]),
    .round_o(rnd[1]), .last_o(last_o[1]),
`ifdef PRESENT_KS_LAST_KEY_EN
    .last_key_o(lk128), .last_key_valid_o(lkv[1]),
`endif
    .state_o(st[1])
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total  = 0;
  int passed = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]   sb[16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0]  m_rk[2][32];
  logic [127:0] m_full[2];
  logic [63:0]  held_rk[2] = '{64'h0, 64'h0};
  logic [127:0] m_lk[2]    = '{128'h0, 128'h0};
  bit           m_lkv[2]   = '{1'b0, 1'b0};
  bit           busy[2]    = '{1'b0, 1'b0};
  int           n[2]       = '{0, 0};

  // Expand a user key into its 32 round keys plus the final full key register.
  function automatic void build(input int d, input logic [127:0] key);
    logic [127:0] k, mask;
    int w;
    w    = wid[d];
    mask = (w == 80) ? {48'h0, {80{1'b1}}} : {128{1'b1}};
    k    = key & mask;
    for (int c = 1; c <= 32; c++) begin
      m_rk[d][c-1] = 64'(k >> (w - 64));
      if (c < 32) begin
        k = ((k << 61) | (k >> (w - 61))) & mask;
        k[w-4 +: 4] = sb[k[w-4 +: 4]];
        if (w == 128) k[w-8 +: 4] = sb[k[w-8 +: 4]];
        k = k ^ ({123'h0, 5'(c)} << ((w == 80) ? 15 : 62));
      end
    end
    m_full[d] = k;
  endfunction

  // Reference PRESENT encryption using the model's schedule for instance d.
  function automatic logic [63:0] encrypt(input int d, input logic [63:0] pt);
    logic [63:0] s, t;
    s = pt;
    for (int r = 0; r < 31; r++) begin
      s = s ^ m_rk[d][r];
      for (int i = 0; i < 16; i++) s[4*i +: 4] = sb[s[4*i +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
      s = t;
    end
    return s ^ m_rk[d][31];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        busy[d] = 1'b0; n[d] = 0; held_rk[d] = '0; m_lk[d] = '0; m_lkv[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!busy[d]) begin
          if (kv[d]) begin
            build(d, key_in[d]);
            busy[d] = 1'b1; n[d] = 0; m_lkv[d] = 1'b0;
          end
        end else if (rr[d]) begin
          if (n[d] == 31) begin
            busy[d] = 1'b0; held_rk[d] = m_rk[d][31];
            m_lk[d] = m_full[d]; m_lkv[d] = 1'b1;
          end else begin
            n[d] = n[d] + 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking && !rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ready[%0d]", d), 128'(kr[d]), 128'(!busy[d]));
        check($sformatf("valid[%0d]", d), 128'(rv[d]), 128'(busy[d]));
        check($sformatf("state[%0d]", d), 128'(st[d]), 128'(busy[d] ? RUN : IDLE));
        check($sformatf("rk[%0d]", d), 128'(rk[d]), 128'(busy[d] ? m_rk[d][n[d]] : held_rk[d]));
        check($sformatf("round[%0d]", d), 128'(rnd[d]), 128'(busy[d] ? 5'((n[d] + 1) % 32) : 5'd0));
        check($sformatf("last[%0d]", d), 128'(last_o[d]), 128'(busy[d] && n[d] == 31));
`ifdef PRESENT_KS_LAST_KEY_EN
        check($sformatf("last_key_valid[%0d]", d), 128'(lkv[d]), 128'(m_lkv[d]));
        if (m_lkv[d])
          check($sformatf("last_key[%0d]", d), (d == 0) ? {48'h0, lk80} : lk128, m_lk[d]);
`endif
      end
    end
  end

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic load(input int d, input logic [127:0] key);
    int guard;
    guard = 0;
    key_in[d] = key;
    kv[d] = 1'b1;
    do begin
      @(posedge clk);
      guard++;
    end while (!kr[d] && guard < 200);
    check($sformatf("load_accepted[%0d]", d), 128'(guard < 200), 128'(1));
    @(negedge clk);
    kv[d] = 1'b0;
  endtask

  task automatic drain(input int d, input int ready_pct, output int hs, output int lasts);
    int guard;
    bit done;
    guard = 0; done = 1'b0; hs = 0; lasts = 0;
    while (!done && guard < 3000) begin
      rr[d] = ($urandom_range(99) < ready_pct);
      @(posedge clk);
      guard++;
      if (rv[d] && rr[d]) begin
        hs++;
        if (last_o[d]) begin
          lasts++;
          done = 1'b1;
        end
      end
      @(negedge clk);
    end
    rr[d] = 1'b0;
    check($sformatf("drain_done[%0d]", d), 128'(done), 128'(1));
  endtask

  // ---------------- stimulus ----------------
  int hs, lasts, guard;
  logic [127:0] k2;

  initial begin
    for (int d = 0; d < 2; d++) begin
      key_in[d] = '0; kv[d] = 1'b0; rr[d] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready[%0d]", d), 128'(kr[d]), 128'(1));
      check($sformatf("rst_valid[%0d]", d), 128'(rv[d]), 128'(0));
      check($sformatf("rst_rk[%0d]", d), 128'(rk[d]), 128'(0));
      check($sformatf("rst_round[%0d]", d), 128'(rnd[d]), 128'(0));
      check($sformatf("rst_last[%0d]", d), 128'(last_o[d]), 128'(0));
    end
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);

    // 80-bit all-zero key: literal round keys and sequence length.
    load(0, '0);
    check("z80_rk1", 128'(rk[0]), 128'h0);
    check("z80_round1", 128'(rnd[0]), 128'd1);
    rr[0] = 1'b1;
    @(negedge clk);
    check("z80_rk2", 128'(rk[0]), 128'hC000000000000000);
    check("z80_round2", 128'(rnd[0]), 128'd2);
    drain(0, 100, hs, lasts);
    check("z80_handshakes", 128'(hs + 1), 128'd32);
    check("z80_last_once", 128'(lasts), 128'd1);
    check("enc_k0_p0", 128'(encrypt(0, 64'h0)), 128'h5579C1387B228445);

    // 80-bit all-ones key end to end.
    load(0, {128{1'b1}});
    drain(0, 100, hs, lasts);
    check("ones_handshakes", 128'(hs), 128'd32);
    check("enc_k1_p0", 128'(encrypt(0, 64'h0)), 128'hE72C46C0F5945049);
    check("enc_k1_p1", 128'(encrypt(0, {64{1'b1}})), 128'h3333DCD3213210D2);

    // 128-bit all-zero key.
    load(1, '0);
    check("z128_rk1", 128'(rk[1]), 128'h0);
    rr[1] = 1'b1;
    @(negedge clk);
    check("z128_rk2", 128'(rk[1]), 128'hCC00000000000000);
    drain(1, 100, hs, lasts);
    check("z128_handshakes", 128'(hs + 1), 128'd32);

    // Backpressure after rk3.
    load(0, {$urandom, $urandom, $urandom, $urandom});
    rr[0] = 1'b1;
    repeat (2) @(negedge clk);
    rr[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_round", 128'(rnd[0]), 128'd3);
      check("bp_rk3", 128'(rk[0]), 128'(m_rk[0][2]));
    end
    rr[0] = 1'b1;
    @(negedge clk);
    check("bp_rk4", 128'(rk[0]), 128'(m_rk[0][3]));
    check("bp_round4", 128'(rnd[0]), 128'd4);
    drain(0, 100, hs, lasts);

    // Key offered during RUN is ignored; back-to-back load after the final handshake.
    load(0, {$urandom, $urandom, $urandom, $urandom});
    k2 = {$urandom, $urandom, $urandom, $urandom};
    key_in[0] = k2;
    kv[0] = 1'b1;
    check("run_ready_low", 128'(kr[0]), 128'd0);
    drain(0, 100, hs, lasts);
    check("run_ignore_len", 128'(hs), 128'd32);
    check("idle_ready", 128'(kr[0]), 128'd1);
    @(negedge clk);
    kv[0] = 1'b0;
    check("b2b_valid", 128'(rv[0]), 128'd1);
    check("b2b_rk1", 128'(rk[0]), 128'(k2[79:16]));
    drain(0, 70, hs, lasts);

    // Reset in the middle of a sequence.
    load(0, {$urandom, $urandom, $urandom, $urandom});
    rr[0] = 1'b1;
    guard = 0;
    while (rnd[0] != 5'd10 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reached_round10", 128'(guard < 100), 128'd1);
    rr[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", 128'(kr[0]), 128'd1);
    check("mid_rst_valid", 128'(rv[0]), 128'd0);
    check("mid_rst_rk", 128'(rk[0]), 128'd0);
    check("mid_rst_round", 128'(rnd[0]), 128'd0);
    check("mid_rst_last", 128'(last_o[0]), 128'd0);
`ifdef PRESENT_KS_LAST_KEY_EN
    check("mid_rst_lkv", 128'(lkv[0]), 128'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    load(0, k2);
    check("restart_rk1", 128'(rk[0]), 128'(k2[79:16]));
    check("restart_round1", 128'(rnd[0]), 128'd1);
`ifdef PRESENT_KS_LAST_KEY_EN
    check("restart_lkv", 128'(lkv[0]), 128'd0);
`endif
    drain(0, 100, hs, lasts);

    // Randomized keys and backpressure on both widths concurrently.
    for (int it = 0; it < 4; it++) begin
      fork
        begin
          int h0, l0;
          load(0, {$urandom, $urandom, $urandom, $urandom});
          drain(0, 60, h0, l0);
        end
        begin
          int h1, l1;
          load(1, {$urandom, $urandom, $urandom, $urandom});
          drain(1, 60, h1, l1);
        end
      join
    end

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
